mem_write_checker: RTL and testbench
====================================

MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the bus address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the bus data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, range 1..16, meaning the number of entries in the expected-write table.
REQ-004 The block SHALL have parameter TIMEOUT, default 1024, meaning the run-cycle budget.
REQ-005 The block SHALL have parameter IGN_ADDR, default 80, meaning the scratch address whose writes are ignored.
REQ-006 The block SHALL have parameter IGN_EN, default 1, meaning the ignore rule is enabled.
REQ-007 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-008 Port rst, input, 1 bit: reset, synchronous and active-low.
REQ-009 Port memwrite, input, 1 bit: bus write strobe, sampled each rising edge.
REQ-010 Port dataadr, input, ADDR_W bits: write address.
REQ-011 Port writedata, input, DATA_W bits: write data.
REQ-012 Port cfg_we, input, 1 bit: table write strobe.
REQ-013 Port cfg_idx, input, clog2(DEPTH) bits (min 1): table entry index.
REQ-014 Port cfg_addr, input, ADDR_W bits: expected address for the entry.
REQ-015 Port cfg_data, input, DATA_W bits: expected data for the entry.
REQ-016 Port cfg_len, input, clog2(DEPTH)+1 bits: number of active entries.
REQ-017 Port start, input, 1 bit: single-cycle pulse that arms the checker.
REQ-018 Port done, output, 1 bit: high in any terminal state.
REQ-019 Port pass, output, 1 bit: high only in PASS.
REQ-020 Port fail_code, output, 2 bits: 0 none, 1 address mismatch, 2 data mismatch, 3 timeout.
REQ-021 Port fail_addr, output, ADDR_W bits: captured address of the offending write.
REQ-022 Port fail_data, output, DATA_W bits: captured data of the offending write.
REQ-023 Port match_cnt, output, clog2(DEPTH)+1 bits: number of entries matched so far.

Function
REQ-024 The state machine SHALL have states IDLE, RUN, PASS, FAIL and TMO; PASS, FAIL and TMO are terminal.
REQ-025 Accepted: cfg_we in any state other than RUN SHALL write {cfg_addr, cfg_data} to entry cfg_idx on that edge.
REQ-026 Ignored: cfg_we in RUN SHALL be ignored, and cfg_idx >= DEPTH SHALL be ignored.
REQ-027 In IDLE or any terminal state, start SHALL on the same edge enter RUN, latch cfg_len, and clear match_cnt, the cycle counter, fail_code, fail_addr and fail_data.
REQ-028 start in RUN SHALL be ignored.
REQ-029 start with latched cfg_len = 0 SHALL enter PASS on the next edge.
REQ-030 In RUN with memwrite high: dataadr == table[match_cnt].addr and writedata == table[match_cnt].data -> match_cnt increments.
REQ-031 In RUN, when the increment makes match_cnt == cfg_len, the block SHALL enter PASS on that edge.
REQ-032 In RUN, a write with IGN_EN=1 and dataadr == IGN_ADDR that does not match the current entry SHALL be ignored and leave the state unchanged.
REQ-033 Precedence: an exact match SHALL take precedence over the ignore rule.
REQ-034 In RUN, a write with dataadr equal to the expected address and data differing -> FAIL with fail_code=2.
REQ-035 In RUN, any other non-ignored write -> FAIL with fail_code=1.
REQ-036 On every FAIL entry, fail_addr and fail_data SHALL capture that write's address and data.
REQ-037 The cycle counter SHALL increment each RUN cycle.
REQ-038 When the counter reaches TIMEOUT-1 with no terminal transition on that edge, the block SHALL enter TMO with fail_code=3 on that edge.
REQ-039 A match or failure on the same edge as the timeout SHALL take precedence over the timeout.
REQ-040 In terminal states, memwrite SHALL be ignored and all outputs held until start or reset.
REQ-041 done and pass SHALL be registered outputs, asserted in the cycle after the decisive edge.
REQ-042 match_cnt SHALL saturate at cfg_len.

Reset
REQ-043 With rst low at a rising edge, the state SHALL become IDLE and done, pass, fail_code, fail_addr, fail_data and match_cnt SHALL become 0.
REQ-044 Reset SHALL take priority over start, cfg_we and memwrite, including during RUN.
REQ-045 Table contents SHALL be unaffected by reset, and latched cfg_len SHALL be cleared to 0.

Verification
REQ-046 Table {84,7}, len 1, start; writes (80,5),(80,9),(84,7) -> PASS, done=1, pass=1, match_cnt=1, fail_code=0.
REQ-047 Table {84,7}, len 1; write (84,6) -> FAIL, fail_code=2, fail_addr=84, fail_data=6.
REQ-048 Table {84,7}, len 1; write (88,7) -> FAIL, fail_code=1, fail_addr=88, fail_data=7.
REQ-049 Table {84,7}, len 1, TIMEOUT=16, no writes -> TMO at cycle 16 after start, fail_code=3.
REQ-050 Table {(80,1),(84,7)}, len 2; writes (80,1),(84,7) -> PASS with match_cnt=2, confirming match-over-ignore precedence.
REQ-051 rst low mid-RUN after 1 match, then start with len 1 and write (84,7) -> outputs cleared, then PASS.

Source files
------------

// File: rtl/mem_write_checker.sv
// mem_write_checker: scores bus writes against a programmable table of expected
// (address, data) pairs and reports pass, mismatch or timeout.
module mem_write_checker #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 1024,
  parameter int IGN_ADDR = 80,
  parameter int IGN_EN   = 1,
  localparam int IW      = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [LW-1:0]     cfg_len,
  input  logic              start,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [LW-1:0]     match_cnt
);
  // Headroom past TIMEOUT because a match on the timeout edge defers the timeout.
  localparam int CW = $clog2(TIMEOUT) + LW + 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] tbl_addr_q [DEPTH];
  logic [ADDR_W-1:0] tbl_addr_d [DEPTH];
  logic [DATA_W-1:0] tbl_data_q [DEPTH];
  logic [DATA_W-1:0] tbl_data_d [DEPTH];
  logic [LW-1:0]     len_q, len_d, match_q, match_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        code_q, code_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;
  logic              done_q, done_d, pass_q, pass_d;
  logic              in_rng, adr_hit, hit, ign;

  assign in_rng  = match_q < LW'(DEPTH);
  assign adr_hit = in_rng && dataadr == tbl_addr_q[match_q[IW-1:0]];
  assign hit     = adr_hit && writedata == tbl_data_q[match_q[IW-1:0]];
  assign ign     = (IGN_EN != 0) && dataadr == ADDR_W'(IGN_ADDR);

  always_comb begin
    tbl_addr_d = tbl_addr_q;
    tbl_data_d = tbl_data_q;
    if (rst && cfg_we && state_q != S_RUN && {1'b0, cfg_idx} < (IW+1)'(DEPTH)) begin
      tbl_addr_d[cfg_idx] = cfg_addr;
      tbl_data_d[cfg_idx] = cfg_data;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    match_d = match_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    if (state_q == S_RUN) begin
      cnt_d = cnt_q + 1'b1;
      if (len_q == '0) begin
        state_d = S_PASS;
      end else if (memwrite && hit) begin
        match_d = match_q + 1'b1;
        state_d = match_d == len_q ? S_PASS : S_RUN;
      end else if (memwrite && !ign) begin
        state_d = S_FAIL;
        code_d  = adr_hit ? 2'd2 : 2'd1;
        faddr_d = dataadr;
        fdata_d = writedata;
      end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
        state_d = S_TMO;
        code_d  = 2'd3;
      end
    end else if (start) begin
      state_d = S_RUN;
      len_d   = cfg_len;
      match_d = '0;
      cnt_d   = '0;
      code_d  = '0;
      faddr_d = '0;
      fdata_d = '0;
    end
    done_d = state_d == S_PASS || state_d == S_FAIL || state_d == S_TMO;
    pass_d = state_d == S_PASS;
  end

  always_ff @(posedge clk) begin
    tbl_addr_q <= tbl_addr_d;
    tbl_data_q <= tbl_data_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      match_q <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = code_q;
  assign fail_addr = faddr_q;
  assign fail_data = fdata_q;
  assign match_cnt = match_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed vector table plus hand sequences around the timeout edge.
module tb_mem_write_checker;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic [2:0]  cfg_len = '0;
  logic        start = 1'b0;
  logic        done, pass;
  logic [1:0]  fail_code;
  logic [31:0] fail_addr, fail_data;
  logic [2:0]  match_cnt;

  int checks = 0;
  int failures = 0;

  mem_write_checker #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len(cfg_len), .start(start), .done(done), .pass(pass), .fail_code(fail_code),
    .fail_addr(fail_addr), .fail_data(fail_data), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, st, mw;
    logic [31:0] adr, dat;
    logic        we;
    logic [1:0]  idx;
    logic [31:0] ca, cd;
    logic [2:0]  len;
    logic        e_done, e_pass;
    logic [1:0]  e_code;
    logic [31:0] e_fa, e_fd;
    logic [2:0]  e_m;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic st, logic mw, int adr, int dat, logic we, int idx,
                              int ca, int cd, int len, logic ed, logic ep, int ec, int efa,
                              int efd, int em);
    vec_t v;
    v.r = r; v.st = st; v.mw = mw; v.adr = adr; v.dat = dat; v.we = we; v.idx = 2'(idx);
    v.ca = ca; v.cd = cd; v.len = 3'(len); v.e_done = ed; v.e_pass = ep; v.e_code = 2'(ec);
    v.e_fa = efa; v.e_fd = efd; v.e_m = 3'(em);
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic st, logic mw, int adr, int dat, int len);
    rst = 1'b1; start = st; memwrite = mw; dataadr = adr; writedata = dat;
    cfg_we = 1'b0; cfg_len = 3'(len);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(int idx, int a, int d);
    drive(0, 0, 0, 0, 0);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // Start, idle up to edge 14, write w15 on edge 15 and w16 on edge 16.
  task automatic late_pair(int a16, int d16);
    drive(1, 0, 0, 0, 2);
    tick();
    for (int k = 1; k <= 14; k++) begin
      drive(0, 0, 0, 0, 0);
      tick();
    end
    drive(0, 1, 84, 7, 0);
    tick();
    drive(0, 1, a16, d16, 0);
    tick();
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    vq.push_back(mk(0,0,0,  0, 0, 0,0,  0, 0,0, 0,0,0,  0,0,0));
    vq.push_back(mk(1,0,0,  0, 0, 1,0, 84, 7,0, 0,0,0,  0,0,0));
    vq.push_back(mk(1,1,0,  0, 0, 0,0,  0, 0,1, 0,0,0,  0,0,0));
    vq.push_back(mk(1,0,1, 80, 5, 0,0,  0, 0,0, 0,0,0,  0,0,0));
    vq.push_back(mk(1,0,1, 80, 9, 0,0,  0, 0,0, 0,0,0,  0,0,0));
    vq.push_back(mk(1,0,1, 84, 7, 0,0,  0, 0,0, 1,1,0,  0,0,1));
    vq.push_back(mk(1,0,1, 88, 1, 0,0,  0, 0,0, 1,1,0,  0,0,1));
    vq.push_back(mk(1,1,0,  0, 0, 0,0,  0, 0,1, 0,0,0,  0,0,0));
    vq.push_back(mk(1,0,1, 84, 6, 0,0,  0, 0,0, 1,0,2, 84,6,0));
    vq.push_back(mk(1,0,1, 84, 7, 0,0,  0, 0,0, 1,0,2, 84,6,0));
    vq.push_back(mk(1,1,0,  0, 0, 0,0,  0, 0,1, 0,0,0,  0,0,0));
    vq.push_back(mk(1,0,1, 88, 7, 0,0,  0, 0,0, 1,0,1, 88,7,0));
    vq.push_back(mk(1,0,0,  0, 0, 1,0, 80, 1,0, 1,0,1, 88,7,0));
    vq.push_back(mk(1,0,0,  0, 0, 1,1, 84, 7,0, 1,0,1, 88,7,0));
    vq.push_back(mk(1,1,0,  0, 0, 0,0,  0, 0,2, 0,0,0,  0,0,0));
    vq.push_back(mk(1,0,1, 80, 2, 0,0,  0, 0,0, 0,0,0,  0,0,0));
    vq.push_back(mk(1,0,1, 80, 1, 0,0,  0, 0,0, 0,0,0,  0,0,1));
    vq.push_back(mk(1,0,1, 84, 7, 0,0,  0, 0,0, 1,1,0,  0,0,2));
    vq.push_back(mk(1,1,0,  0, 0, 0,0,  0, 0,0, 0,0,0,  0,0,0));
    vq.push_back(mk(1,0,0,  0, 0, 0,0,  0, 0,0, 1,1,0,  0,0,0));
    vq.push_back(mk(1,1,0,  0, 0, 0,0,  0, 0,1, 0,0,0,  0,0,0));
    vq.push_back(mk(1,0,0,  0, 0, 1,0, 84, 7,0, 0,0,0,  0,0,0));
    vq.push_back(mk(1,0,1, 80, 1, 0,0,  0, 0,0, 1,1,0,  0,0,1));
    vq.push_back(mk(1,1,0,  0, 0, 0,0,  0, 0,2, 0,0,0,  0,0,0));
    vq.push_back(mk(1,0,1, 80, 1, 0,0,  0, 0,0, 0,0,0,  0,0,1));
    vq.push_back(mk(0,1,1, 84, 7, 1,0, 84, 7,1, 0,0,0,  0,0,0));
    vq.push_back(mk(1,1,0,  0, 0, 0,0,  0, 0,2, 0,0,0,  0,0,0));
    vq.push_back(mk(1,0,1, 80, 1, 0,0,  0, 0,0, 0,0,0,  0,0,1));
    vq.push_back(mk(1,0,1, 84, 7, 0,0,  0, 0,0, 1,1,0,  0,0,2));
    vq.push_back(mk(1,0,0,  0, 0, 1,0, 84, 7,0, 1,1,0,  0,0,2));
    vq.push_back(mk(1,1,0,  0, 0, 0,0,  0, 0,1, 0,0,0,  0,0,0));
    vq.push_back(mk(1,0,1, 84, 7, 0,0,  0, 0,0, 1,1,0,  0,0,1));

    foreach (vq[i]) begin
      rst = vq[i].r; start = vq[i].st; memwrite = vq[i].mw; dataadr = vq[i].adr;
      writedata = vq[i].dat; cfg_we = vq[i].we; cfg_idx = vq[i].idx; cfg_addr = vq[i].ca;
      cfg_data = vq[i].cd; cfg_len = vq[i].len;
      tick();
      chk($sformatf("v%0d.done", i), 64'(done), 64'(vq[i].e_done));
      chk($sformatf("v%0d.pass", i), 64'(pass), 64'(vq[i].e_pass));
      chk($sformatf("v%0d.code", i), 64'(fail_code), 64'(vq[i].e_code));
      chk($sformatf("v%0d.faddr", i), 64'(fail_addr), 64'(vq[i].e_fa));
      chk($sformatf("v%0d.fdata", i), 64'(fail_data), 64'(vq[i].e_fd));
      chk($sformatf("v%0d.match", i), 64'(match_cnt), 64'(vq[i].e_m));
    end

    // Timeout with no writes: terminal on edge 16 after the start edge.
    begin
      int hit_edge;
      hit_edge = -1;
      drive(1, 0, 0, 0, 1);
      tick();
      for (int k = 1; k <= 40 && hit_edge < 0; k++) begin
        drive(0, 0, 0, 0, 0);
        tick();
        if (done) hit_edge = k;
      end
      chk("tmo.edge", 64'(hit_edge), 64'(TMO));
      chk("tmo.code", 64'(fail_code), 64'd3);
      chk("tmo.pass", 64'(pass), 64'd0);
    end

    // Final match on the timeout edge wins over the timeout.
    cfg(1, 88, 3);
    late_pair(88, 3);
    chk("late_match.pass", 64'(pass), 64'd1);
    chk("late_match.code", 64'(fail_code), 64'd0);
    chk("late_match.match", 64'(match_cnt), 64'd2);

    // Address mismatch on the timeout edge wins over the timeout.
    late_pair(99, 0);
    chk("late_fail.done", 64'(done), 64'd1);
    chk("late_fail.code", 64'(fail_code), 64'd1);
    chk("late_fail.faddr", 64'(fail_addr), 64'd99);
    chk("late_fail.match", 64'(match_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
